// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Collects operand A, operand B and an opcode from a shared switch bus using
// Enter/Undo pulses. It presents them to an external combinational ALU and
// captures that ALU's result and flags for display. No arithmetic is done here.
module alu_operand_sequencer #(
    parameter int M     = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [M-1:0]     DataIn,
    input  logic             Enter,
    input  logic             Undo,
    input  logic [M-1:0]     AluResult,
    input  logic [4:0]       AluFlags,
    output logic [M-1:0]     A,
    output logic [M-1:0]     B,
    output logic [1:0]       OpCode,
    output logic [M-1:0]     ResultReg,
    output logic [4:0]       FlagsReg,
    output logic [M-1:0]     Display,
    output logic [2:0]       State,
    output logic             ResultValid,
    output logic [CNT_W-1:0] OpCount
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'b000,
        WAIT_B  = 3'b001,
        WAIT_OP = 3'b010,
        CALC    = 3'b011,
        SHOW    = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic [M-1:0]     a_q, a_d;
    logic [M-1:0]     b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [M-1:0]     res_q, res_d;
    logic [4:0]       flg_q, flg_d;
    logic             rv_q, rv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state and register-load decisions; Enter always beats Undo.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flg_d   = flg_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_A: begin
                if (Enter) begin
                    a_d     = DataIn;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (Enter) begin
                    b_d     = DataIn;
                    state_d = WAIT_OP;
                end else if (Undo) begin
                    state_d = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (Enter) begin
                    op_d    = DataIn[1:0];
                    state_d = CALC;
                end else if (Undo) begin
                    state_d = WAIT_B;
                end
            end
            CALC: begin
                // The ALU has had a full cycle on the registered operands;
                // the button inputs are deliberately ignored here.
                res_d   = AluResult;
                flg_d   = AluFlags;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = SHOW;
            end
            SHOW: begin
                if (Enter) begin
                    state_d = WAIT_A;
                end else if (Undo) begin
                    state_d = WAIT_OP;
                end
            end
            default: state_d = WAIT_A;
        endcase
        // SHOW is only reachable from CALC, so this flag rises on CALC->SHOW
        // and drops on any exit from SHOW.
        rv_d = (state_d == SHOW);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            rv_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            rv_q    <= rv_d;
            cnt_q   <= cnt_d;
        end
    end

    // Display selects live switch value while entering data, result afterwards.
    always_comb begin
        case (state_q)
            WAIT_A, WAIT_B: Display = DataIn;
            WAIT_OP:        Display = {{(M-2){1'b0}}, DataIn[1:0]};
            default:        Display = res_q;
        endcase
    end

    assign A           = a_q;
    assign B           = b_q;
    assign OpCode      = op_q;
    assign ResultReg   = res_q;
    assign FlagsReg    = flg_q;
    assign State       = state_q;
    assign ResultValid = rv_q;
    assign OpCount     = cnt_q;

endmodule
